// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache refill path.
// Line = WNUM words, delivered as NBEAT beats of WBKSZ words each.
// Holds the refill FSM state encoding and a beat-to-word-address helper.
package icache_pkg;

    localparam int WORDSZ  = 32;
    localparam int WNUM    = 8;
    localparam int WBKSZ   = 2;
    localparam int LNUM    = 64;
    localparam int NBEAT   = WNUM / WBKSZ;

    localparam int LADDR_W = $clog2(LNUM);
    localparam int WADDR_W = $clog2(WNUM);
    localparam int BEAT_W  = $clog2(NBEAT);
    localparam int WBK_W   = $clog2(WBKSZ);

    typedef logic [WORDSZ-1:0]  word_t;
    typedef logic [LADDR_W-1:0] laddr_t;
    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [BEAT_W-1:0]  beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_TAG  = 2'd3
    } refill_state_e;

    // First word index covered by a beat (beat * WBKSZ).
    function automatic waddr_t beat_to_waddr(input beat_t beat);
        return waddr_t'({beat, {WBK_W{1'b0}}});
    endfunction

endpackage

// File: rtl/icache_refill.sv
// I-cache line refill: accepts a miss, issues one memory read, streams NBEAT beats into the data array, then writes tag/valid.
// Latency: refill_done NBEAT+2 cycles after miss accept with no memory stalls; beats pass straight through to the data array.
// Backpressure: miss_ready only in IDLE; memory stalls hold all state. Macro ICACHE_REFILL_CWF_EN enables critical-word-first.
module icache_refill
    import icache_pkg::*;
#(
    parameter int TAGSZ  = 20,
    parameter int ADDRSZ = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_valid,
    output logic                    miss_ready,
    input  logic [TAGSZ-1:0]        miss_tag,
    input  laddr_t                  miss_laddr,
    input  waddr_t                  miss_waddr,
    input  logic                    flush,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDRSZ-1:0]       mem_req_addr,
    input  logic                    mem_resp_valid,
    input  word_t [WBKSZ-1:0]       mem_resp_data,
    output logic                    mem_resp_ready,
    output laddr_t                  laddrb,
    output waddr_t                  waddrb,
    output word_t [WBKSZ-1:0]       din,
    output logic                    we,
    output logic                    tag_we,
    output laddr_t                  tag_laddr,
    output logic [TAGSZ-1:0]        tag_din,
    output logic                    refill_done,
    output logic                    busy
);

    refill_state_e      state_q, state_d;
    logic               kill_q, kill_d;
    beat_t              cnt_q, cnt_d;
    beat_t              start_q, start_d;
    logic [TAGSZ-1:0]   tag_q, tag_d;
    laddr_t             laddr_q, laddr_d;

    logic               miss_hs;
    logic               beat_hs;
    logic               kill_now;
    beat_t              miss_start;
    beat_t              beat_idx;

    assign miss_hs  = miss_valid && (state_q == ST_IDLE);
    assign beat_hs  = mem_resp_valid && (state_q == ST_FILL);
    // A flush seen this cycle already suppresses this cycle's write.
    assign kill_now = kill_q || (flush && ((state_q == ST_REQ) || (state_q == ST_FILL)));
    // Beat index wraps naturally because NBEAT is a power of two.
    assign beat_idx = start_q + cnt_q;

`ifdef ICACHE_REFILL_CWF_EN
    assign miss_start = beat_t'(miss_waddr >> WBK_W);
`else
    logic unused_miss_waddr;
    assign unused_miss_waddr = ^miss_waddr;
    assign miss_start        = '0;
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            start_q <= '0;
            tag_q   <= '0;
            laddr_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            tag_q   <= tag_d;
            laddr_q <= laddr_d;
        end
    end

    // Next-state: one request, NBEAT beats, one tag cycle per miss.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (miss_valid)    state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready) state_d = ST_FILL;
            ST_FILL: if (mem_resp_valid && (cnt_q == beat_t'(NBEAT - 1))) state_d = ST_TAG;
            ST_TAG:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture miss fields, count beats, track a sticky flush for the current line.
    always_comb begin
        tag_d   = tag_q;
        laddr_d = laddr_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        if (miss_hs) begin
            tag_d   = miss_tag;
            laddr_d = miss_laddr;
            start_d = miss_start;
            cnt_d   = '0;
        end
        if (beat_hs) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Kill is meaningful only while the line is in flight; leaving TAG clears it.
        kill_d = ((state_q == ST_REQ) || (state_q == ST_FILL)) ? kill_now : 1'b0;
    end

    // Outputs decoded from state; idle-side values are all zero except miss_ready.
    always_comb begin
        miss_ready     = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        mem_req_valid  = (state_q == ST_REQ);
        mem_req_addr   = '0;
        if (state_q == ST_REQ) begin
            mem_req_addr = ADDRSZ'({tag_q, laddr_q, beat_to_waddr(start_q), 2'b00});
        end
        mem_resp_ready = (state_q == ST_FILL);

        we     = beat_hs && !kill_now;
        laddrb = we ? laddr_q : '0;
        waddrb = we ? beat_to_waddr(beat_idx) : '0;
        din    = we ? mem_resp_data : '0;

        tag_we      = (state_q == ST_TAG) && !kill_q;
        tag_laddr   = tag_we ? laddr_q : '0;
        tag_din     = tag_we ? tag_q : '0;
        refill_done = tag_we;
    end

    // Memory must only return beats after the request has been accepted.
    mem_resp_in_fill_a: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_valid |-> (state_q == ST_FILL));

endmodule
